// File: rtl/serial_rx_unit.sv
// serial_rx_unit: 8N1 UART receiver with receive FIFO for the console path.
// Ports: clk, negResetIn (sync, active-low), rxd (async line, idle high),
//   serialRE (pop), serialReadData/serialReadValid (popped byte, 1-cycle
//   pulse), rxNotEmpty, rxCount (occupancy), rxOverrun/frameError/
//   parityError (sticky), errorClear (clears all sticky flags).
// Option: define RSD_SERIAL_RX_PARITY_EN for an even-parity bit
//   (11-bit frame); otherwise parityError is tied to 0.
module serial_rx_unit #(
  parameter int CLKS_PER_BIT = 543,
  parameter int FIFO_DEPTH   = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                            clk,
  input  logic                            negResetIn,
  input  logic                            rxd,
  input  logic                            serialRE,
  output logic [DATA_WIDTH-1:0]           serialReadData,
  output logic                            serialReadValid,
  output logic                            rxNotEmpty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rxCount,
  output logic                            rxOverrun,
  output logic                            frameError,
  output logic                            parityError,
  input  logic                            errorClear
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [TW-1:0] FULL_T   = TW'(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_T   = TW'(CLKS_PER_BIT / 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  // ---------------- input synchronizer ----------------
  logic rx_meta_q;
  logic rxs_q;

  always_ff @(posedge clk) begin
    if (!negResetIn) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rxs_q     <= rx_meta_q;
    end
  end

  // ---------------- receive FSM ----------------
  state_e                state_q;
  logic [TW-1:0]         timer_q;
  logic [BW-1:0]         bit_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  push_q;
  logic [DATA_WIDTH-1:0] push_data_q;
  logic                  fe_set_q;
  logic                  expire;

  // Timer is loaded with the interval length and expires on its
  // last cycle, so a load of N spends exactly N cycles in the state.
  assign expire = (timer_q == TW'(1));

`ifdef RSD_SERIAL_RX_PARITY_EN
  logic par_bad_q;
  logic pe_set_q;
`endif

  always_ff @(posedge clk) begin
    if (!negResetIn) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      fe_set_q    <= 1'b0;
`ifdef RSD_SERIAL_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      pe_set_q    <= 1'b0;
`endif
    end else begin
      push_q   <= 1'b0;
      fe_set_q <= 1'b0;
`ifdef RSD_SERIAL_RX_PARITY_EN
      pe_set_q <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_q <= S_START;
            timer_q <= HALF_T;
          end
        end
        S_START: begin
          if (expire) begin
            if (rxs_q) begin
              // Line back high at mid start bit: glitch.
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DATA;
              timer_q <= FULL_T;
              bit_q   <= '0;
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_DATA: begin
          if (expire) begin
            shift_q <= {rxs_q, shift_q[DATA_WIDTH-1:1]};
            timer_q <= FULL_T;
            if (bit_q == LAST_BIT) begin
`ifdef RSD_SERIAL_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
`ifdef RSD_SERIAL_RX_PARITY_EN
        S_PARITY: begin
          if (expire) begin
            // Even parity: data bits plus parity bit XOR to 0.
            par_bad_q <= (^shift_q) ^ rxs_q;
            pe_set_q  <= (^shift_q) ^ rxs_q;
            state_q   <= S_STOP;
            timer_q   <= FULL_T;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
`endif
        S_STOP: begin
          if (expire) begin
            if (rxs_q) begin
`ifdef RSD_SERIAL_RX_PARITY_EN
              push_q <= !par_bad_q;
`else
              push_q <= 1'b1;
`endif
              push_data_q <= shift_q;
              state_q     <= S_IDLE;
            end else begin
              fe_set_q <= 1'b1;
              state_q  <= S_BREAK;
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_BREAK: begin
          // Held-low line: wait for idle so only one error is flagged.
          if (rxs_q) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------- receive FIFO ----------------
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         head_q;
  logic [PW-1:0]         head_d;
  logic [PW-1:0]         tail_q;
  logic [PW-1:0]         tail_d;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  nempty_q;
  logic                  pop;
  logic                  full;
  logic                  wr;
  logic                  ovr;

  always_comb begin
    pop     = serialRE && (count_q != '0);
    full    = (count_q == DEPTH_C);
    // A pop in the same cycle frees the slot for a push into a full FIFO.
    wr      = push_q && (!full || pop);
    ovr     = push_q && full && !pop;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (wr) begin
      tail_d = tail_q + PW'(1);
    end
    count_d = count_q + CW'(wr) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[tail_q] <= push_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!negResetIn) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      nempty_q <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      nempty_q <= (count_d != '0);
      valid_q  <= pop;
      if (pop) begin
        data_q <= mem_q[head_q];
      end
    end
  end

  // ---------------- sticky error flags ----------------
  logic ovr_q;
  logic fe_q;

  // Set wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!negResetIn) begin
      ovr_q <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      ovr_q <= ovr | (ovr_q & ~errorClear);
      fe_q  <= fe_set_q | (fe_q & ~errorClear);
    end
  end

`ifdef RSD_SERIAL_RX_PARITY_EN
  logic pe_q;

  always_ff @(posedge clk) begin
    if (!negResetIn) begin
      pe_q <= 1'b0;
    end else begin
      pe_q <= pe_set_q | (pe_q & ~errorClear);
    end
  end

  assign parityError = pe_q;
`else
  assign parityError = 1'b0;
`endif

  assign serialReadData  = data_q;
  assign serialReadValid = valid_q;
  assign rxNotEmpty      = nempty_q;
  assign rxCount         = count_q;
  assign rxOverrun       = ovr_q;
  assign frameError      = fe_q;

endmodule

// File: tb/tb_serial_rx_unit.sv
// tb_serial_rx_unit: scoreboard bench for serial_rx_unit
// (CLKS_PER_BIT=16, FIFO_DEPTH=4).
module tb_serial_rx_unit;

  localparam int BIT = 16;
  localparam int DEP = 4;

  logic       clk = 1'b0;
  logic       negResetIn = 1'b0;
  logic       rxd = 1'b1;
  logic       serialRE = 1'b0;
  logic       errorClear = 1'b0;
  logic [7:0] serialReadData;
  logic       serialReadValid;
  logic       rxNotEmpty;
  logic [2:0] rxCount;
  logic       rxOverrun;
  logic       frameError;
  logic       parityError;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovr = 1'b0;

  serial_rx_unit #(
    .CLKS_PER_BIT(BIT),
    .FIFO_DEPTH  (DEP),
    .DATA_WIDTH  (8)
  ) dut (
    .clk            (clk),
    .negResetIn     (negResetIn),
    .rxd            (rxd),
    .serialRE       (serialRE),
    .serialReadData (serialReadData),
    .serialReadValid(serialReadValid),
    .rxNotEmpty     (rxNotEmpty),
    .rxCount        (rxCount),
    .rxOverrun      (rxOverrun),
    .frameError     (frameError),
    .parityError    (parityError),
    .errorClear     (errorClear)
  );

  always #5 clk = ~clk;

  // Scoreboard: every popped byte must match the oldest expected byte.
  always @(negedge clk) begin
    if (negResetIn && serialReadValid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h, none expected",
                 serialReadData);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (serialReadData !== e) begin
          errors++;
          $display("FAIL pop_data: got %h exp %h", serialReadData, e);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rxd = bits[i];
      cyc(BIT);
    end
    rxd = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    if (exp_q.size() < DEP) exp_q.push_back(d);
    else exp_ovr = 1'b1;
    send_frame({6'b0, 1'b1, d, 1'b0}, 10);
    cyc(4);
  endtask

  task automatic do_pop();
    serialRE = 1'b1;
    cyc(1);
    serialRE = 1'b0;
  endtask

  task automatic clear_err();
    errorClear = 1'b1;
    cyc(1);
    errorClear = 1'b0;
    exp_ovr = 1'b0;
  endtask

  task automatic test_reset();
    negResetIn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rxd = i[0];
      cyc(1);
    end
    checks++;
    if ({serialReadData, serialReadValid, rxNotEmpty, rxCount,
         rxOverrun, frameError, parityError} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outs: got %h/%b/%b/%0d/%b%b%b exp all 0",
               serialReadData, serialReadValid, rxNotEmpty, rxCount,
               rxOverrun, frameError, parityError);
    end
    rxd = 1'b1;
    cyc(1);
    negResetIn = 1'b1;
    cyc(40);
    checks++;
    if (rxCount !== 3'd0 || frameError !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: cnt %0d fe %b exp 0 0",
               rxCount, frameError);
    end
  endtask

  task automatic test_single();
    int lat;
    lat = -1;
    fork
      send_byte(8'h55);
      begin
        for (int c = 0; c < 300; c++) begin
          @(posedge clk);
          #1;
          if (rxCount == 3'd1) begin
            lat = c + 1;
            break;
          end
        end
      end
    join
    checks++;
    if (lat < 150 || lat > 170) begin
      errors++;
      $display("FAIL latency_55: got %0d exp 150..170", lat);
    end
    checks++;
    if (rxNotEmpty !== 1'b1 || rxCount !== 3'd1) begin
      errors++;
      $display("FAIL occ_55: ne %b cnt %0d exp 1 1", rxNotEmpty, rxCount);
    end
    do_pop();
    checks++;
    if (serialReadValid !== 1'b1) begin
      errors++;
      $display("FAIL valid_55: got %b exp 1", serialReadValid);
    end
    cyc(1);
    checks++;
    if (rxCount !== 3'd0 || rxNotEmpty !== 1'b0 || serialReadValid !== 1'b0
        || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_55: cnt %0d ne %b v %b left %0d exp 0 0 0 0",
               rxCount, rxNotEmpty, serialReadValid, exp_q.size());
    end
  endtask

  task automatic test_glitch();
    rxd = 1'b0;
    cyc(5);
    rxd = 1'b1;
    cyc(60);
    checks++;
    if (rxCount !== 3'd0 || rxNotEmpty !== 1'b0) begin
      errors++;
      $display("FAIL glitch_cnt: cnt %0d ne %b exp 0 0", rxCount, rxNotEmpty);
    end
    checks++;
    if ({rxOverrun, frameError, parityError} !== 3'b000) begin
      errors++;
      $display("FAIL glitch_flags: got %b%b%b exp 000",
               rxOverrun, frameError, parityError);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 5; i++) send_byte(8'h41 + 8'(i));
    checks++;
    if (rxCount !== 3'(DEP) || rxNotEmpty !== 1'b1) begin
      errors++;
      $display("FAIL ovr_cnt: cnt %0d ne %b exp 4 1", rxCount, rxNotEmpty);
    end
    checks++;
    if (rxOverrun !== exp_ovr) begin
      errors++;
      $display("FAIL ovr_flag: got %b exp %b", rxOverrun, exp_ovr);
    end
    // Back-to-back pops, one byte per cycle.
    for (int i = 0; i < DEP; i++) begin
      do_pop();
      checks++;
      if (serialReadValid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_valid%0d: got %b exp 1", i, serialReadValid);
      end
    end
    do_pop();
    checks++;
    if (serialReadValid !== 1'b0 || serialReadData !== 8'h44) begin
      errors++;
      $display("FAIL empty_pop: v %b d %h exp 0 44",
               serialReadValid, serialReadData);
    end
    cyc(1);
    checks++;
    if (rxCount !== 3'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ovr_drain: cnt %0d left %0d exp 0 0",
               rxCount, exp_q.size());
    end
    clear_err();
    checks++;
    if (rxOverrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: got %b exp 0", rxOverrun);
    end
  endtask

  task automatic test_frame_error();
    send_frame({6'b0, 1'b0, 8'hA5, 1'b0}, 10);
    rxd = 1'b0;
    cyc(40);
    rxd = 1'b1;
    cyc(20);
    checks++;
    if (frameError !== 1'b1 || rxCount !== 3'd0) begin
      errors++;
      $display("FAIL frame_err: fe %b cnt %0d exp 1 0", frameError, rxCount);
    end
    send_byte(8'h3C);
    checks++;
    if (rxCount !== 3'd1) begin
      errors++;
      $display("FAIL frame_next: cnt %0d exp 1", rxCount);
    end
    do_pop();
    cyc(1);
    checks++;
    if (exp_q.size() != 0 || frameError !== 1'b1) begin
      errors++;
      $display("FAIL frame_sticky: left %0d fe %b exp 0 1",
               exp_q.size(), frameError);
    end
    clear_err();
    checks++;
    if (frameError !== 1'b0) begin
      errors++;
      $display("FAIL frame_clear: got %b exp 0", frameError);
    end
  endtask

  task automatic test_parity();
    logic exp_fe;
    logic exp_pe;
`ifdef RSD_SERIAL_RX_PARITY_EN
    exp_fe = 1'b0;
    exp_pe = 1'b1;
`else
    exp_fe = 1'b1;
    exp_pe = 1'b0;
`endif
    // Good parity: accepted either way (without parity the parity bit
    // is read as a valid stop bit).
    exp_q.push_back(8'h07);
    send_frame({4'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    cyc(4);
    send_frame({4'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    cyc(20);
    checks++;
    if (parityError !== exp_pe || frameError !== exp_fe) begin
      errors++;
      $display("FAIL parity_flags: pe %b fe %b exp %b %b",
               parityError, frameError, exp_pe, exp_fe);
    end
    checks++;
    if (rxCount !== 3'd1) begin
      errors++;
      $display("FAIL parity_cnt: got %0d exp 1", rxCount);
    end
    do_pop();
    cyc(1);
    checks++;
    if (exp_q.size() != 0 || rxCount !== 3'd0) begin
      errors++;
      $display("FAIL parity_drain: left %0d cnt %0d exp 0 0",
               exp_q.size(), rxCount);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_overrun();
    test_frame_error();
    test_parity();
    cyc(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
